// File: rtl/qcl_pkg.sv
// qcl_pkg: types shared by the qcl accumulating framer and its sum datapath.
package qcl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } qcl_framer_state_e;

endpackage

// File: rtl/qcl_accum_clr.sv
// qcl_accum_clr: registered adder; when enabled, load_i replaces the sum with data_i, otherwise data_i is added.
module qcl_accum_clr #(
    parameter int width_p = 16
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               en_i,
    input  logic               load_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] next_o,
    output logic [width_p-1:0] sum_o
);

    assign next_o = load_i ? data_i : sum_o + data_i;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) sum_o <= '0;
        else if (en_i) sum_o <= next_o;
    end

endmodule

// File: rtl/qcl_accum_framer.sv
// qcl_accum_framer: sums unsigned beats into frames of frame_len_i beats (or until flush_i)
// and holds each result on sum_o/count_o until the consumer takes it with yumi_i.
module qcl_accum_framer
    import qcl_pkg::*;
#(
    parameter int width_p       = 8,
    parameter int count_width_p = 8
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic                             v_i,
    input  logic [width_p-1:0]               data_i,
    output logic                             ready_o,
    input  logic [count_width_p-1:0]         frame_len_i,
    input  logic                             flush_i,
    output logic                             v_o,
    output logic [width_p+count_width_p-1:0] sum_o,
    output logic [count_width_p-1:0]         count_o,
    input  logic                             yumi_i
);

    localparam int sum_width_p = width_p + count_width_p;
    localparam logic [count_width_p-1:0] cnt_one = count_width_p'(1);

    qcl_framer_state_e state_r, state_n;
    logic [count_width_p-1:0] count_r, count_n, len_r, len_first;
    logic [sum_width_p-1:0]   acc_next, acc_r;
    logic                     beat, first, close;

    assign beat      = v_i & ready_o;
    assign first     = state_r == IDLE;
    assign len_first = (frame_len_i == '0) ? cnt_one : frame_len_i;
    assign count_n   = !beat ? count_r : first ? cnt_one : count_r + cnt_one;

    qcl_accum_clr #(.width_p(sum_width_p)) u_accum (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .en_i     (beat),
        .load_i   (first),
        .data_i   (sum_width_p'(data_i)),
        .next_o   (acc_next),
        .sum_o    (acc_r)
    );

    always_comb begin
        ready_o = state_r != HOLD;
        v_o     = state_r == HOLD;
        close   = 1'b0;
        state_n = state_r;
        unique case (state_r)
            IDLE: begin
                close   = beat & ((len_first == cnt_one) | flush_i);
                state_n = close ? HOLD : beat ? ACCUM : IDLE;
            end
            ACCUM: begin
                close   = (beat & (count_n == len_r)) | flush_i;
                state_n = close ? HOLD : ACCUM;
            end
            default: state_n = yumi_i ? IDLE : HOLD;
        endcase
    end

    // Results are captured only on closing a frame so sum_o/count_o never show partial sums.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= IDLE;
            count_r <= '0;
            len_r   <= '0;
            sum_o   <= '0;
            count_o <= '0;
        end else begin
            state_r <= state_n;
            count_r <= count_n;
            if (beat & first) len_r <= len_first;
            if (close) begin
                sum_o   <= beat ? acc_next : acc_r;
                count_o <= count_n;
            end
        end
    end

    yumi_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);

endmodule

// File: tb/tb_qcl_accum_framer.sv
// tb_qcl_accum_framer: directed frames plus a randomized backpressure run, checked by a
// scoreboard queue that a monitor drains whenever the framer presents a result.
module tb_qcl_accum_framer;

    localparam int w  = 8;
    localparam int cw = 8;
    localparam int sw = w + cw;

    logic          clk_i = 1'b0;
    logic          reset_n_i = 1'b0;
    logic          v_i = 1'b0;
    logic          flush_i = 1'b0;
    logic          yumi_i = 1'b0;
    logic [w-1:0]  data_i = '0;
    logic [cw-1:0] frame_len_i = '0;
    logic          ready_o, v_o;
    logic [sw-1:0] sum_o;
    logic [cw-1:0] count_o;

    int vectors = 0;
    int miscompares = 0;
    int yumi_mode = 0;
    int hold_cnt = 0;
    logic [sw+cw-1:0] exp_q[$];

    always #5 clk_i = ~clk_i;

    qcl_accum_framer #(.width_p(w), .count_width_p(cw)) dut (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .v_i        (v_i),
        .data_i     (data_i),
        .ready_o    (ready_o),
        .frame_len_i(frame_len_i),
        .flush_i    (flush_i),
        .v_o        (v_o),
        .sum_o      (sum_o),
        .count_o    (count_o),
        .yumi_i     (yumi_i)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int s, input int c);
        exp_q.push_back({sw'(s), cw'(c)});
    endtask

    task automatic beat(input int d, input int len, input bit fl);
        int n = 0;
        while (!ready_o && n < 400) begin
            @(negedge clk_i);
            n++;
        end
        if (!ready_o) check("ready_timeout", 32'(ready_o), 1);
        v_i = 1'b1;
        data_i = w'(d);
        frame_len_i = cw'(len);
        flush_i = fl;
        @(negedge clk_i);
        v_i = 1'b0;
        flush_i = 1'b0;
    endtask

    task automatic flush_only();
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk_i);
        check("queue_drained", 32'(exp_q.size()), 0);
        @(negedge clk_i);
    endtask

    // Monitor: compares every cycle a result is shown (stability) and acts as the consumer.
    always @(negedge clk_i) begin
        logic y;
        y = 1'b0;
        if (reset_n_i && v_o) begin
            check("ready_in_hold", 32'(ready_o), 0);
            if (exp_q.size() == 0) check("unexpected_v_o", 32'(v_o), 0);
            else begin
                check("sum_o", 32'(sum_o), 32'(exp_q[0][sw+cw-1:cw]));
                check("count_o", 32'(count_o), 32'(exp_q[0][cw-1:0]));
                y = (yumi_mode == 0) ? 1'b1 : (yumi_mode == 1) ? (hold_cnt == 10) : ($urandom_range(0, 2) == 0);
                hold_cnt = y ? 0 : hold_cnt + 1;
                if (y) void'(exp_q.pop_front());
            end
        end
        yumi_i = y;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check("rst_v_o", 32'(v_o), 0);
        check("rst_ready_o", 32'(ready_o), 1);
        check("rst_sum_o", 32'(sum_o), 0);
        check("rst_count_o", 32'(count_o), 0);
        #11 reset_n_i = 1'b1;
        @(negedge clk_i);

        // len=4, beats 1..4 back-to-back, immediate yumi
        push(10, 4);
        for (int i = 1; i <= 4; i++) beat(i, 4, 1'b0);
        check("latency_v_o", 32'(v_o), 1);
        check("ready_low_cycle", 32'(ready_o), 0);
        @(negedge clk_i);
        check("ready_back", 32'(ready_o), 1);
        check("v_o_dropped", 32'(v_o), 0);

        // flush on third beat of a len=5 frame
        push(60, 3);
        beat(10, 5, 1'b0);
        beat(20, 0, 1'b0);
        beat(30, 0, 1'b1);
        drain();

        // flush with no beat while accumulating
        push(11, 2);
        beat(5, 5, 1'b0);
        beat(6, 5, 1'b0);
        flush_only();
        drain();

        // len=0 behaves as len=1; flush alone in IDLE is ignored
        push(7, 1);
        beat(7, 0, 1'b0);
        drain();
        flush_only();
        check("flush_idle_v_o", 32'(v_o), 0);
        @(negedge clk_i);
        check("flush_idle_v_o2", 32'(v_o), 0);
        check("flush_idle_ready", 32'(ready_o), 1);

        // max frame, result held for 10 cycles; a flush in HOLD is ignored
        yumi_mode = 1;
        hold_cnt = 0;
        for (int i = 1; i <= 255; i++) begin
            if (i == 255) push(65025, 255);
            beat(255, 255, 1'b0);
        end
        flush_only();
        drain();
        yumi_mode = 0;

        // asynchronous reset mid-frame discards the partial sum
        beat(50, 5, 1'b0);
        beat(60, 5, 1'b0);
        #2 reset_n_i = 1'b0;
        #1;
        check("arst_v_o", 32'(v_o), 0);
        check("arst_sum_o", 32'(sum_o), 0);
        check("arst_count_o", 32'(count_o), 0);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        push(7, 2);
        beat(3, 2, 1'b0);
        beat(4, 2, 1'b0);
        drain();

        // randomized frames with gaps, early flushes and random consumer stalls
        yumi_mode = 2;
        for (int f = 0; f < 1000; f++) begin
            int len, le, s, c, d;
            bit fl, done;
            len = $urandom_range(0, 6);
            le = (len == 0) ? 1 : len;
            s = 0;
            c = 0;
            done = 1'b0;
            while (!done) begin
                if ($urandom_range(0, 3) == 0) @(negedge clk_i);
                if (c > 0 && $urandom_range(0, 15) == 0) begin
                    push(s, c);
                    flush_only();
                    done = 1'b1;
                end else begin
                    d = $urandom_range(0, 255);
                    fl = $urandom_range(0, 9) == 0;
                    s += d;
                    c++;
                    done = fl || c == le;
                    if (done) push(s, c);
                    beat(d, (c == 1) ? len : $urandom_range(0, 255), fl);
                end
            end
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
